// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between the sweeper, its controller and the expression block.
// The slave side is the sweeper; the master side drives start/abort and returns Y.
interface truth_table_sweeper_if;
   logic        start;
   logic        abort;
   logic        y_in;
   logic        a_out;
   logic        b_out;
   logic        c_out;
   logic        d_out;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] captured;
   logic [4:0]  fail_count;
   logic [3:0]  first_fail_idx;
   logic        fail_valid;

   modport master (
      output start, abort, y_in,
      input  a_out, b_out, c_out, d_out, busy, done, pass,
             captured, fail_count, first_fail_idx, fail_valid
   );

   modport slave (
      input  start, abort, y_in,
      output a_out, b_out, c_out, d_out, busy, done, pass,
             captured, fail_count, first_fail_idx, fail_valid
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks all 16 {A,B,C,D} input combinations, samples Y after a settle delay and
// compares the captured truth table against EXPECTED.
module truth_table_sweeper #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [15:0] EXPECTED      = 16'h4EF4
) (
   input logic                  clk,
   input logic                  rst_n,
   truth_table_sweeper_if.slave bus
);

   if (SETTLE_CYCLES > 15) begin : g_settle_range
      $error("SETTLE_CYCLES must be in 0..15");
   end

   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

   // With no settle time a vector goes straight to SAMPLE and WAIT is never used.
   localparam state_t     VEC_START   = (SETTLE_CYCLES == 0) ? SAMPLE : WAIT;
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t      state;
   logic [3:0]  idx;
   logic [3:0]  cnt;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] captured;
   logic [4:0]  fail_count;
   logic [3:0]  first_fail_idx;
   logic        fail_valid;
   logic        miss;

   always_comb begin
      miss = (bus.y_in != EXPECTED[idx]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         idx            <= '0;
         cnt            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         captured       <= '0;
         fail_count     <= '0;
         first_fail_idx <= '0;
         fail_valid     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               // abort alongside start blocks the start
               if (bus.start && !bus.abort) begin
                  state          <= VEC_START;
                  idx            <= '0;
                  cnt            <= '0;
                  busy           <= 1'b1;
                  pass           <= 1'b0;
                  captured       <= '0;
                  fail_count     <= '0;
                  first_fail_idx <= '0;
                  fail_valid     <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (bus.abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cnt == SETTLE_LAST) begin
                  state <= SAMPLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            SAMPLE: begin
               if (bus.abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  captured[idx] <= bus.y_in;
                  if (miss) begin
                     fail_count <= fail_count + 5'd1;
                     if (!fail_valid) begin
                        first_fail_idx <= idx;
                        fail_valid     <= 1'b1;
                     end
                  end
                  if (idx == 4'd15) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (fail_count == 5'd0) && !miss;
                  end else begin
                     state <= VEC_START;
                     idx   <= idx + 4'd1;
                     cnt   <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.a_out          = idx[3];
   assign bus.b_out          = idx[2];
   assign bus.c_out          = idx[1];
   assign bus.d_out          = idx[0];
   assign bus.busy           = busy;
   assign bus.done           = done;
   assign bus.pass           = pass;
   assign bus.captured       = captured;
   assign bus.fail_count     = fail_count;
   assign bus.first_fail_idx = first_fail_idx;
   assign bus.fail_valid     = fail_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 0 and 1) driven by a
// table-emulated expression block, checked against a truth-table model.
module tb_truth_table_sweeper;
   localparam logic [15:0] EXP = 16'h4EF4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   truth_table_sweeper_if if0 ();
   truth_table_sweeper_if if1 ();

   // Emulated expression blocks: Y is looked up from a programmable table.
   logic [15:0] tbl0;
   logic [15:0] tbl1;
   always_comb if0.y_in = tbl0[{if0.a_out, if0.b_out, if0.c_out, if0.d_out}];
   always_comb if1.y_in = tbl1[{if1.a_out, if1.b_out, if1.c_out, if1.d_out}];

   truth_table_sweeper #(.SETTLE_CYCLES(0), .EXPECTED(EXP)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0)
   );
   truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(EXP)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      string       name;
      int          d;
      bit          repulse;
      logic [15:0] tbl;
      logic [15:0] cap;
      int          fc;
      int          ffi;
      bit          fv;
      bit          ps;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] nib(input int d);
      if (d == 0) return {if0.a_out, if0.b_out, if0.c_out, if0.d_out};
      return {if1.a_out, if1.b_out, if1.c_out, if1.d_out};
   endfunction

   function automatic logic get_done(input int d);
      return (d == 0) ? if0.done : if1.done;
   endfunction

   function automatic logic get_busy(input int d);
      return (d == 0) ? if0.busy : if1.busy;
   endfunction

   task automatic set_start(input int d, input logic v);
      if (d == 0) if0.start = v; else if1.start = v;
   endtask

   // Reference: the sweep captures the block's table verbatim and scores it bitwise.
   task automatic model(input logic [15:0] t, output logic [15:0] cap, output int fc,
                        output int ffi, output bit fv, output bit ps);
      logic [15:0] e;
      e   = EXP;
      cap = t;
      fc  = 0;
      ffi = 0;
      fv  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (t[i] !== e[i]) begin
            fc++;
            if (!fv) begin
               ffi = i;
               fv  = 1'b1;
            end
         end
      end
      ps = (fc == 0);
   endtask

   task automatic check_res(input string nm, input int d, input logic [15:0] cap, input int fc,
                            input int ffi, input bit fv, input bit ps);
      logic [15:0] c;
      logic [4:0]  f;
      logic [3:0]  fi;
      logic        v;
      logic        p;
      if (d == 0) begin
         c = if0.captured; f = if0.fail_count; fi = if0.first_fail_idx;
         v = if0.fail_valid; p = if0.pass;
      end else begin
         c = if1.captured; f = if1.fail_count; fi = if1.first_fail_idx;
         v = if1.fail_valid; p = if1.pass;
      end
      chk($sformatf("%s.captured", nm), 32'(c), 32'(cap));
      chk($sformatf("%s.fail_count", nm), 32'(f), 32'(fc));
      chk($sformatf("%s.fail_valid", nm), 32'(v), 32'(fv));
      if (fv) chk($sformatf("%s.first_fail_idx", nm), 32'(fi), 32'(ffi));
      chk($sformatf("%s.pass", nm), 32'(p), 32'(ps));
   endtask

   // Runs one sweep; returns at the cycle where done is high (or after the budget).
   task automatic sweep(input string nm, input int d, input logic [15:0] tbl, input bit repulse);
      int settle;
      int lat;
      int idx_bad;
      int exp_idx;
      settle  = (d == 0) ? 0 : 1;
      if (d == 0) tbl0 = tbl; else tbl1 = tbl;
      set_start(d, 1'b1);
      tick();
      set_start(d, 1'b0);
      chk($sformatf("%s.busy_after_start", nm), 32'(get_busy(d)), 32'd1);
      lat     = -1;
      idx_bad = 0;
      for (int n = 1; n <= 200; n++) begin
         if (repulse && n == 5) set_start(d, 1'b1);
         tick();
         if (repulse && n == 5) set_start(d, 1'b0);
         if (get_done(d)) begin
            lat = n;
            break;
         end
         exp_idx = n / (settle + 1);
         if (nib(d) !== 4'(exp_idx)) idx_bad++;
      end
      chk($sformatf("%s.idx_walk", nm), 32'(idx_bad), 32'd0);
      chk($sformatf("%s.done_latency", nm), 32'(lat), 32'(16 * (settle + 1)));
      chk($sformatf("%s.idx_hold", nm), 32'(nib(d)), 32'hF);
      chk($sformatf("%s.busy_at_done", nm), 32'(get_busy(d)), 32'd0);
   endtask

   logic [15:0] m_cap;
   int          m_fc;
   int          m_ffi;
   bit          m_fv;
   bit          m_ps;

   initial begin
      vecs[0] = '{"good_s1",  1, 1'b0, EXP,      EXP,      0, 0, 1'b0, 1'b1};
      vecs[1] = '{"zero_s1",  1, 1'b0, 16'h0000, 16'h0000, 9, 2, 1'b1, 1'b0};
      vecs[2] = '{"ones_s1",  1, 1'b0, 16'hFFFF, 16'hFFFF, 7, 0, 1'b1, 1'b0};
      vecs[3] = '{"good_s0r", 0, 1'b1, EXP,      EXP,      0, 0, 1'b0, 1'b1};

      rst_n     = 1'b0;
      if0.start = 1'b0; if0.abort = 1'b0;
      if1.start = 1'b0; if1.abort = 1'b0;
      tbl0      = EXP;
      tbl1      = EXP;
      tick();
      tick();
      rst_n = 1'b1;
      chk("reset.flags0", 32'({nib(0), if0.busy, if0.done, if0.pass, if0.fail_valid}), 32'd0);
      chk("reset.flags1", 32'({nib(1), if1.busy, if1.done, if1.pass, if1.fail_valid}), 32'd0);
      chk("reset.data1", 32'({if1.captured, if1.fail_count, if1.first_fail_idx}), 32'd0);

      foreach (vecs[i]) begin
         sweep(vecs[i].name, vecs[i].d, vecs[i].tbl, vecs[i].repulse);
         check_res(vecs[i].name, vecs[i].d, vecs[i].cap, vecs[i].fc, vecs[i].ffi,
                   vecs[i].fv, vecs[i].ps);
         tick();
         chk($sformatf("%s.done_one_cycle", vecs[i].name), 32'(get_done(vecs[i].d)), 32'd0);
      end

      // abort together with start in IDLE starts nothing
      if1.start = 1'b1; if1.abort = 1'b1;
      tick();
      if1.start = 1'b0; if1.abort = 1'b0;
      chk("abort_start_idle.busy", 32'(if1.busy), 32'd0);

      // abort mid-sweep at idx 6 keeps partial results and never pulses done
      tbl1 = EXP;
      set_start(1, 1'b1);
      tick();
      set_start(1, 1'b0);
      for (int n = 0; n < 100 && nib(1) != 4'd6; n++) tick();
      chk("abort.reached_idx6", 32'(nib(1)), 32'd6);
      if1.abort = 1'b1;
      tick();
      if1.abort = 1'b0;
      chk("abort.busy", 32'(if1.busy), 32'd0);
      chk("abort.idx_hold", 32'(nib(1)), 32'd6);
      chk("abort.captured_lo", 32'(if1.captured[5:0]), 32'b110100);
      chk("abort.pass", 32'(if1.pass), 32'd0);
      begin
         int seen;
         seen = 0;
         for (int n = 0; n < 40; n++) begin
            if (if1.done || if1.busy) seen++;
            tick();
         end
         chk("abort.stays_idle", 32'(seen), 32'd0);
      end
      sweep("after_abort", 1, EXP, 1'b0);
      check_res("after_abort", 1, EXP, 0, 0, 1'b0, 1'b1);
      tick();

      // reset mid-sweep at idx 9 clears everything with no done
      tbl1 = 16'h0000;
      set_start(1, 1'b1);
      tick();
      set_start(1, 1'b0);
      for (int n = 0; n < 100 && nib(1) != 4'd9; n++) tick();
      chk("rst_mid.reached_idx9", 32'(nib(1)), 32'd9);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_mid.flags", 32'({nib(1), if1.busy, if1.done, if1.pass, if1.fail_valid}), 32'd0);
      chk("rst_mid.data", 32'({if1.captured, if1.fail_count, if1.first_fail_idx}), 32'd0);

      // back-to-back: start held during DONE is accepted there
      sweep("b2b_first", 1, EXP, 1'b0);
      set_start(1, 1'b1);
      tick();
      set_start(1, 1'b0);
      chk("b2b.accept_in_done", 32'(if1.busy), 32'd1);
      begin
         int lat;
         lat = -1;
         for (int n = 1; n <= 200; n++) begin
            tick();
            if (if1.done) begin
               lat = n;
               break;
            end
         end
         chk("b2b.second_done_latency", 32'(lat), 32'd32);
      end
      check_res("b2b_second", 1, EXP, 0, 0, 1'b0, 1'b1);
      tick();

      // random truth tables on both instances
      for (int i = 0; i < 12; i++) begin
         logic [15:0] t;
         int          d;
         d = i % 2;
         t = 16'($urandom);
         if ($urandom_range(0, 2) == 0) t = EXP ^ (16'h1 << $urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) t = EXP;
         model(t, m_cap, m_fc, m_ffi, m_fv, m_ps);
         sweep($sformatf("rand%0d", i), d, t, 1'b0);
         check_res($sformatf("rand%0d", i), d, m_cap, m_fc, m_ffi, m_fv, m_ps);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
